// File: rtl/tmr_voted_pipeline_if.sv
// tmr_voted_pipeline_if: datapath, error-report and fault-injection signals of the TMR pipeline
interface tmr_voted_pipeline_if #(
    parameter int WIDTH     = 8,
    parameter int DEPTH     = 3,
    parameter int CNT_WIDTH = 8
);
    localparam int STAGE_W = DEPTH > 1 ? $clog2(DEPTH) : 1;
    logic                 en;
    logic                 in_valid;
    logic [WIDTH-1:0]     in_data;
    logic                 out_valid;
    logic [WIDTH-1:0]     out_data;
    logic [DEPTH-1:0]     err_stage;
    logic                 err_any;
    logic [CNT_WIDTH-1:0] err_cnt;
    logic                 err_clr;
    logic                 inj_en;
    logic [1:0]           inj_copy;
    logic [STAGE_W-1:0]   inj_stage;
    logic [WIDTH-1:0]     inj_mask;
    modport master (
        output en, in_valid, in_data, err_clr, inj_en, inj_copy, inj_stage, inj_mask,
        input  out_valid, out_data, err_stage, err_any, err_cnt
    );
    modport slave (
        input  en, in_valid, in_data, err_clr, inj_en, inj_copy, inj_stage, inj_mask,
        output out_valid, out_data, err_stage, err_any, err_cnt
    );
endinterface

// File: rtl/tmr_voted_pipeline.sv
// tmr_voted_pipeline: triple-redundant register pipeline with majority voting, scrubbing and upset counting
module tmr_voted_pipeline #(
    parameter int WIDTH     = 8,
    parameter int DEPTH     = 3,
    parameter int CNT_WIDTH = 8
) (
    input logic clk,
    input logic rst,
    tmr_voted_pipeline_if.slave bus
);
    // Bit WIDTH of every word is the valid flag, so valid is voted exactly like data.
    logic [WIDTH:0]       q   [3][DEPTH];
    logic [WIDTH:0]       d   [3][DEPTH];
    logic [WIDTH:0]       v   [DEPTH];
    logic [WIDTH:0]       nx  [DEPTH];
    logic [DEPTH-1:0]     err;
    logic [CNT_WIDTH-1:0] cnt;
    always_comb begin
        for (int s = 0; s < DEPTH; s++) begin
            v[s]   = (q[0][s] & q[1][s]) | (q[0][s] & q[2][s]) | (q[1][s] & q[2][s]);
            err[s] = (q[0][s] != q[1][s]) || (q[0][s] != q[2][s]);
        end
        nx[0] = bus.en ? {bus.in_valid, bus.in_data} : v[0];
        for (int s = 1; s < DEPTH; s++)
            nx[s] = bus.en ? v[s-1] : v[s];
        for (int c = 0; c < 3; c++)
            for (int s = 0; s < DEPTH; s++)
                d[c][s] = nx[s] ^ ((bus.inj_en && int'(bus.inj_copy) == c && int'(bus.inj_stage) == s)
                                   ? {1'b0, bus.inj_mask} : '0);
    end
    always_ff @(posedge clk) begin
        for (int c = 0; c < 3; c++)
            for (int s = 0; s < DEPTH; s++)
                q[c][s] <= rst ? '0 : d[c][s];
        if (rst || bus.err_clr)
            cnt <= '0;
        else if (|err && cnt != '1)
            cnt <= cnt + 1'b1;
    end
    assign bus.out_valid = v[DEPTH-1][WIDTH];
    assign bus.out_data  = v[DEPTH-1][WIDTH-1:0];
    assign bus.err_stage = err;
    assign bus.err_any   = |err;
    assign bus.err_cnt   = cnt;
endmodule
